// File: rtl/ysyx_20020207_lsu_pkg.sv
// Shared definitions for the load/store unit: load_ctrl encodings
// (identical to the execute stage) and the LSU state type and values.
package ysyx_20020207_lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE = 2'd0;
    localparam lsu_state_t ST_REQ  = 2'd1;
    localparam lsu_state_t ST_RESP = 2'd2;
    localparam lsu_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/ysyx_20020207_lsu_if.sv
// Data-memory valid/ready bus between the LSU (master) and memory (slave).
// Requests are word-aligned; responses are always accepted.
interface ysyx_20020207_lsu_if;
    import ysyx_20020207_lsu_pkg::*;

    logic            mreq_valid;
    logic            mreq_ready;
    logic            mreq_wen;
    logic [XLEN-1:0] mreq_addr;
    logic [XLEN-1:0] mreq_wdata;
    logic [3:0]      mreq_wstrb;
    logic            mresp_valid;
    logic [XLEN-1:0] mresp_rdata;
    logic            mresp_err;

    modport master (
        output mreq_valid, mreq_wen, mreq_addr, mreq_wdata, mreq_wstrb,
        input  mreq_ready, mresp_valid, mresp_rdata, mresp_err
    );

    modport slave (
        input  mreq_valid, mreq_wen, mreq_addr, mreq_wdata, mreq_wstrb,
        output mreq_ready, mresp_valid, mresp_rdata, mresp_err
    );

endinterface

// File: rtl/ysyx_20020207_lsu_align.sv
// Combinational lane logic for the LSU. Request side: store data lane
// shift, byte strobes and the legality check of an incoming access.
// Response side: extract and extend the addressed byte/half/word.
module ysyx_20020207_lsu_align
    import ysyx_20020207_lsu_pkg::*;
(
    input  logic            req_ren,
    input  logic            req_wen,
    input  logic [1:0]      req_off,
    input  logic [2:0]      req_load_ctrl,
    input  logic [3:0]      req_wmask,
    input  logic [XLEN-1:0] req_st_data,
    output logic [XLEN-1:0] req_wdata,
    output logic [3:0]      req_wstrb,
    output logic            req_fault,
    input  logic [1:0]      rsp_off,
    input  logic [2:0]      rsp_load_ctrl,
    input  logic [XLEN-1:0] rsp_rdata,
    output logic [XLEN-1:0] rsp_load_data
);

    logic [6:0]      strb_wide_s;
    logic [XLEN-1:0] word_s;

    // Move store data and mask into their byte lanes; reads carry no strobes.
    always_comb begin
        strb_wide_s = {3'b000, req_wmask} << req_off;
        req_wdata   = req_st_data << {req_off, 3'b000};
        if (req_wen && !req_ren) begin
            req_wstrb = strb_wide_s[3:0];
        end else begin
            req_wstrb = 4'b0000;
        end
    end

    // Flag accesses that must fault without touching the bus.
    always_comb begin
        req_fault = 1'b0;
        if (req_ren && req_wen) begin
            req_fault = 1'b1;
        end else if (req_ren) begin
            case (req_load_ctrl)
                LOAD_LB, LOAD_LBU: req_fault = 1'b0;
                LOAD_LH, LOAD_LHU: req_fault = req_off[0];
                LOAD_LW:           req_fault = (req_off != 2'b00);
                default:           req_fault = 1'b1;
            endcase
        end else if (req_wen) begin
            // Any strobe pushed beyond lane 3 means the store straddles words.
            req_fault = (strb_wide_s[6:4] != 3'b000)
                     || ((req_wmask == 4'b0011) && req_off[0])
                     || ((req_wmask == 4'b1111) && (req_off != 2'b00));
        end else begin
            req_fault = 1'b0;
        end
    end

    // Shift the addressed lane down, then sign- or zero-extend.
    always_comb begin
        word_s = rsp_rdata >> {rsp_off, 3'b000};
        case (rsp_load_ctrl)
            LOAD_LB:  rsp_load_data = {{24{word_s[7]}}, word_s[7:0]};
            LOAD_LBU: rsp_load_data = {24'h000000, word_s[7:0]};
            LOAD_LH:  rsp_load_data = {{16{word_s[15]}}, word_s[15:0]};
            LOAD_LHU: rsp_load_data = {16'h0000, word_s[15:0]};
            LOAD_LW:  rsp_load_data = word_s;
            default:  rsp_load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/ysyx_20020207_lsu.sv
// Load/store unit: captures one instruction from execute, issues at most one
// word-aligned bus request, and reports exactly one completion pulse.
module ysyx_20020207_lsu
    import ysyx_20020207_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic [3:0]            wmask,
    input  logic [2:0]            load_ctrl,
    output logic                  busy,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic                  out_fault,
    ysyx_20020207_lsu_if.master   mem
);

    lsu_state_t      state_q, state_d;
    logic [1:0]      off_q, off_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic            wen_q, wen_d;
    logic [XLEN-1:0] maddr_q, maddr_d;
    logic [XLEN-1:0] mwdata_q, mwdata_d;
    logic [3:0]      mstrb_q, mstrb_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            fault_q, fault_d;

    logic [XLEN-1:0] wdata_s;
    logic [3:0]      wstrb_s;
    logic            fault_s;
    logic [XLEN-1:0] load_data_s;

    ysyx_20020207_lsu_align u_align (
        .req_ren       (mem_ren),
        .req_wen       (mem_wen),
        .req_off       (addr[1:0]),
        .req_load_ctrl (load_ctrl),
        .req_wmask     (wmask),
        .req_st_data   (st_data),
        .req_wdata     (wdata_s),
        .req_wstrb     (wstrb_s),
        .req_fault     (fault_s),
        .rsp_off       (off_q),
        .rsp_load_ctrl (ctrl_q),
        .rsp_rdata     (mem.mresp_rdata),
        .rsp_load_data (load_data_s)
    );

    // Next-state logic: capture in IDLE, hold the request until accepted,
    // wait for the response, then emit one completion cycle.
    always_comb begin
        state_d  = state_q;
        off_d    = off_q;
        ctrl_d   = ctrl_q;
        wen_d    = wen_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        mstrb_d  = mstrb_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!mem_ren && !mem_wen) begin
                        state_d = ST_DONE;
                        rdata_d = 32'h0000_0000;
                        fault_d = 1'b0;
                    end else if (fault_s) begin
                        state_d = ST_DONE;
                        rdata_d = 32'h0000_0000;
                        fault_d = 1'b1;
                    end else begin
                        state_d  = ST_REQ;
                        off_d    = addr[1:0];
                        ctrl_d   = load_ctrl;
                        wen_d    = mem_wen;
                        maddr_d  = {addr[31:2], 2'b00};
                        mwdata_d = wdata_s;
                        mstrb_d  = wstrb_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem.mreq_ready) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RESP: begin
                if (mem.mresp_valid) begin
                    state_d = ST_DONE;
                    fault_d = mem.mresp_err;
                    if (mem.mresp_err || wen_q) begin
                        rdata_d = 32'h0000_0000;
                    end else begin
                        rdata_d = load_data_s;
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and capture registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            off_q    <= 2'b00;
            ctrl_q   <= 3'b000;
            wen_q    <= 1'b0;
            maddr_q  <= 32'h0000_0000;
            mwdata_q <= 32'h0000_0000;
            mstrb_q  <= 4'b0000;
            rdata_q  <= 32'h0000_0000;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            off_q    <= off_d;
            ctrl_q   <= ctrl_d;
            wen_q    <= wen_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            mstrb_q  <= mstrb_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign out_valid      = (state_q == ST_DONE);
    assign out_rdata      = rdata_q;
    assign out_fault      = fault_q;
    assign mem.mreq_valid = (state_q == ST_REQ);
    assign mem.mreq_wen   = wen_q;
    assign mem.mreq_addr  = maddr_q;
    assign mem.mreq_wdata = mwdata_q;
    assign mem.mreq_wstrb = mstrb_q;

endmodule

// File: tb/tb_ysyx_20020207_lsu.sv
// Self-checking bench for the LSU: directed cases followed by random
// transactions, each compared against an arithmetic reference model.
module tb_ysyx_20020207_lsu;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic [3:0]  wmask;
    logic [2:0]  load_ctrl;
    logic        busy;
    logic        out_valid;
    logic [31:0] out_rdata;
    logic        out_fault;

    int checks   = 0;
    int failures = 0;

    ysyx_20020207_lsu_if bus ();

    ysyx_20020207_lsu #(.DATA_WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .addr      (addr),
        .st_data   (st_data),
        .wmask     (wmask),
        .load_ctrl (load_ctrl),
        .busy      (busy),
        .out_valid (out_valid),
        .out_rdata (out_rdata),
        .out_fault (out_fault),
        .mem       (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        bus;
        logic        fault;
        logic        wen;
        logic [31:0] rdata;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  mstrb;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: what the instruction should do, from byte sizes and offsets.
    function automatic exp_t model(input logic ren, input logic wen, input logic [31:0] a,
                                   input logic [31:0] sd, input logic [3:0] wm, input logic [2:0] lc,
                                   input logic [31:0] word, input logic err);
        exp_t e;
        int off, size;
        longint unsigned val, msk, strb;
        e = '0;
        off = int'(a % 32'd4);
        e.maddr = a - 32'(off);
        if (!ren && !wen) begin
            e.fault = 1'b0;
        end else if (ren && wen) begin
            e.fault = 1'b1;
        end else if (ren) begin
            size = (lc == 3'd0 || lc == 3'd4) ? 1 : (lc == 3'd1 || lc == 3'd5) ? 2 : (lc == 3'd2) ? 4 : 0;
            if (size == 0 || (off % size) != 0) begin
                e.fault = 1'b1;
            end else begin
                e.bus = 1'b1;
                if (err) begin
                    e.fault = 1'b1;
                end else begin
                    val = word;
                    val = val >> (8 * off);
                    msk = (64'd1 << (8 * size)) - 64'd1;
                    val = val & msk;
                    if (lc < 3'd4 && size < 4 && ((val >> (8 * size - 1)) & 64'd1) == 64'd1)
                        val = val | ~msk;
                    e.rdata = val[31:0];
                end
            end
        end else begin
            strb = wm;
            strb = strb << off;
            if (strb > 64'd15 || (wm == 4'b0011 && (off % 2) != 0) || (wm == 4'b1111 && off != 0)) begin
                e.fault = 1'b1;
            end else begin
                e.bus    = 1'b1;
                e.wen    = 1'b1;
                e.mstrb  = strb[3:0];
                e.mwdata = sd << (8 * off);
                e.fault  = err;
            end
        end
        return e;
    endfunction

    // Issue one instruction, play the memory side, and check the outcome.
    task automatic do_txn(input string tag, input logic ren, input logic wen, input logic [31:0] a,
                          input logic [31:0] sd, input logic [3:0] wm, input logic [2:0] lc,
                          input logic [31:0] word, input logic err, input int rdly);
        exp_t e;
        int   cyc, wait_cnt, req_cycles;
        bit   hs_next, hs_done, resp_sent, got;
        e = model(ren, wen, a, sd, wm, lc, word, err);
        cyc = 0; wait_cnt = 0; req_cycles = 0;
        hs_next = 1'b0; hs_done = 1'b0; resp_sent = 1'b0; got = 1'b0;
        chk({tag, ":idle_before_issue"}, {31'd0, busy}, 32'd0);
        in_valid = 1'b1; mem_ren = ren; mem_wen = wen; addr = a;
        st_data = sd; wmask = wm; load_ctrl = lc;
        @(posedge clock); #1;
        in_valid = 1'b0; mem_ren = 1'($urandom); mem_wen = 1'($urandom);
        addr = $urandom; st_data = $urandom; wmask = 4'($urandom); load_ctrl = 3'($urandom);
        cyc = 1;
        chk({tag, ":busy"}, {31'd0, busy}, 32'd1);
        while (!got && cyc < 40) begin
            if (out_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                bus.mreq_ready  = 1'b0;
                bus.mresp_valid = 1'b0;
                bus.mresp_rdata = $urandom;
                bus.mresp_err   = 1'($urandom);
                if (hs_done && !resp_sent) begin
                    bus.mresp_valid = 1'b1;
                    bus.mresp_rdata = word;
                    bus.mresp_err   = err;
                    resp_sent       = 1'b1;
                end else if (!hs_done && $urandom_range(0, 3) == 0) begin
                    bus.mresp_valid = 1'b1;
                end
                if (bus.mreq_valid === 1'b1) begin
                    req_cycles++;
                    chk({tag, ":mreq_addr"}, bus.mreq_addr, e.maddr);
                    chk({tag, ":mreq_wen"}, {31'd0, bus.mreq_wen}, {31'd0, e.wen});
                    chk({tag, ":mreq_wstrb"}, {28'd0, bus.mreq_wstrb}, {28'd0, e.mstrb});
                    if (e.wen) chk({tag, ":mreq_wdata"}, bus.mreq_wdata, e.mwdata);
                    if (wait_cnt >= rdly) begin
                        bus.mreq_ready = 1'b1;
                        hs_next = 1'b1;
                    end else begin
                        wait_cnt++;
                    end
                end
                @(posedge clock); #1;
                cyc++;
                if (hs_next) hs_done = 1'b1;
            end
        end
        bus.mreq_ready  = 1'b0;
        bus.mresp_valid = 1'b0;
        chk({tag, ":completed"}, {31'd0, got}, 32'd1);
        chk({tag, ":latency"}, 32'(cyc), e.bus ? 32'(3 + rdly) : 32'd1);
        chk({tag, ":req_cycles"}, 32'(req_cycles), e.bus ? 32'(rdly + 1) : 32'd0);
        chk({tag, ":out_fault"}, {31'd0, out_fault}, {31'd0, e.fault});
        chk({tag, ":out_rdata"}, out_rdata, e.rdata);
        @(posedge clock); #1;
        chk({tag, ":pulse_one_cycle"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ":idle_after"}, {31'd0, busy}, 32'd0);
        chk({tag, ":rdata_held"}, out_rdata, e.rdata);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
        addr = 32'd0; st_data = 32'd0; wmask = 4'd0; load_ctrl = 3'd0;
        bus.mreq_ready = 1'b0; bus.mresp_valid = 1'b0;
        bus.mresp_rdata = 32'd0; bus.mresp_err = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset:busy", {31'd0, busy}, 32'd0);
        chk("reset:out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset:out_fault", {31'd0, out_fault}, 32'd0);
        chk("reset:out_rdata", out_rdata, 32'd0);
        chk("reset:mreq_valid", {31'd0, bus.mreq_valid}, 32'd0);
        chk("reset:mreq_wen", {31'd0, bus.mreq_wen}, 32'd0);
        chk("reset:mreq_addr", bus.mreq_addr, 32'd0);
        chk("reset:mreq_wdata", bus.mreq_wdata, 32'd0);
        chk("reset:mreq_wstrb", {28'd0, bus.mreq_wstrb}, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        do_txn("lw_basic", 1'b1, 1'b0, 32'h8000_0004, 32'd0, 4'b0000, 3'b010, 32'hDEAD_BEEF, 1'b0, 0);
        do_txn("lb_sext", 1'b1, 1'b0, 32'h8000_0003, 32'd0, 4'b0000, 3'b000, 32'h80FF_0000, 1'b0, 0);
        do_txn("lbu_zext", 1'b1, 1'b0, 32'h8000_0003, 32'd0, 4'b0000, 3'b100, 32'h80FF_0000, 1'b0, 0);
        do_txn("lh_sext", 1'b1, 1'b0, 32'h8000_0002, 32'd0, 4'b0000, 3'b001, 32'h9234_5678, 1'b0, 1);
        do_txn("lhu_zext", 1'b1, 1'b0, 32'h8000_0002, 32'd0, 4'b0000, 3'b101, 32'h9234_5678, 1'b0, 0);
        do_txn("sh_lane2", 1'b0, 1'b1, 32'h8000_0002, 32'h0000_1234, 4'b0011, 3'b000, 32'h0, 1'b0, 0);
        do_txn("lw_misaligned", 1'b1, 1'b0, 32'h8000_0001, 32'd0, 4'b0000, 3'b010, 32'h0, 1'b0, 0);
        do_txn("non_mem", 1'b0, 1'b0, 32'h1234_5677, 32'hFFFF_FFFF, 4'b1111, 3'b010, 32'h0, 1'b0, 0);
        do_txn("sw_ready_late", 1'b0, 1'b1, 32'h8000_0010, 32'hCAFE_F00D, 4'b1111, 3'b000, 32'h0, 1'b0, 5);
        do_txn("lw_bus_err", 1'b1, 1'b0, 32'h8000_0008, 32'd0, 4'b0000, 3'b010, 32'h1111_2222, 1'b1, 2);
        do_txn("ren_and_wen", 1'b1, 1'b1, 32'h8000_0000, 32'd0, 4'b1111, 3'b010, 32'h0, 1'b0, 0);
        do_txn("sb_lane3", 1'b0, 1'b1, 32'h8000_0003, 32'h0000_00A5, 4'b0001, 3'b000, 32'h0, 1'b0, 0);
        do_txn("sh_odd", 1'b0, 1'b1, 32'h8000_0001, 32'h0000_BEEF, 4'b0011, 3'b000, 32'h0, 1'b0, 0);
        do_txn("ld_ctrl_011", 1'b1, 1'b0, 32'h8000_0000, 32'd0, 4'b0000, 3'b011, 32'h0, 1'b0, 0);

        // Reset while waiting for the response; a late response must be dropped.
        in_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; addr = 32'h8000_0020; load_ctrl = 3'b010;
        @(posedge clock); #1;
        in_valid = 1'b0; mem_ren = 1'b0;
        chk("rst_mid:mreq_valid", {31'd0, bus.mreq_valid}, 32'd1);
        bus.mreq_ready = 1'b1;
        @(posedge clock); #1;
        bus.mreq_ready = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("rst_mid:busy", {31'd0, busy}, 32'd0);
        chk("rst_mid:mreq_valid_drop", {31'd0, bus.mreq_valid}, 32'd0);
        reset = 1'b0;
        bus.mresp_valid = 1'b1; bus.mresp_rdata = 32'h5555_AAAA; bus.mresp_err = 1'b0;
        @(posedge clock); #1;
        bus.mresp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_mid:no_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_mid:busy_after", {31'd0, busy}, 32'd0);
            @(posedge clock); #1;
        end

        for (int n = 0; n < 150; n++) begin
            logic        r_ren, r_wen, r_err;
            logic [31:0] r_addr;
            logic [3:0]  r_wm;
            int          kind;
            kind  = $urandom_range(0, 9);
            r_ren = (kind <= 3) || (kind == 7);
            r_wen = (kind >= 4 && kind <= 7);
            r_addr = {4'h8, 28'($urandom)};
            case ($urandom_range(0, 3))
                0:       r_wm = 4'b0001;
                1:       r_wm = 4'b0011;
                2:       r_wm = 4'b1111;
                default: r_wm = 4'($urandom);
            endcase
            r_err = ($urandom_range(0, 7) == 0);
            do_txn("random", r_ren, r_wen, r_addr, $urandom, r_wm, 3'($urandom_range(0, 7)),
                   $urandom, r_err, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
